// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the sliced ALU sequencer: FSM state encoding,
// operation-select encoding and the initial carry-in rule.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Arithmetic-mode operation select. Bits [2:1] pick the second adder
    // operand (0, B, ~B, all-ones); the carry-in comes from initial_carry().
    typedef enum logic [2:0] {
        OP_PASS_A = 3'b000,  // A + 0
        OP_INC    = 3'b001,  // A + 0 + 1
        OP_ADD    = 3'b010,  // A + B
        OP_ADD1   = 3'b011,  // A + B + 1
        OP_SUBM1  = 3'b100,  // A + ~B       (A - B - 1)
        OP_SUB    = 3'b101,  // A + ~B + 1   (A - B)
        OP_DEC    = 3'b110,  // A + ones     (A - 1)
        OP_DEC_X  = 3'b111   // A + ones     (A - 1)
    } opsel_e;

    // Carry fed into the least-significant slice of an operation.
    function automatic logic initial_carry(input logic [2:0] opsel, input logic mode);
        logic cin;
        cin = 1'b0;
        if (!mode) begin
            case (opsel)
                OP_INC, OP_ADD1, OP_SUB: cin = 1'b1;
                default:                 cin = 1'b0;
            endcase
        end
        return cin;
    endfunction

endpackage

// File: rtl/alu_slice_sequencer.sv
// Runs one DATA_W-wide ALU operation as NSLICE passes through an external
// SLICE_W-wide combinational ALU slice, least-significant slice first, with
// the slice carry-out chained into the next pass.
module alu_slice_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int SLICE_W = 32
) (
    input  logic               Clk,
    input  logic               Reset_n,
    // request side
    input  logic               ReqValid,
    output logic               ReqReady,
    input  logic [2:0]         ReqOpsel,
    input  logic               ReqMode,
    input  logic [DATA_W-1:0]  ReqA,
    input  logic [DATA_W-1:0]  ReqB,
    // shared slice interface
    output logic [2:0]         SliceOpsel,
    output logic               SliceMode,
    output logic               SliceCin,
    output logic [SLICE_W-1:0] SliceA,
    output logic [SLICE_W-1:0] SliceB,
    input  logic [SLICE_W-1:0] SliceResult,
    input  logic               SliceCout,
    // response side
    output logic               RspValid,
    input  logic               RspReady,
    output logic [DATA_W-1:0]  RspResult,
    output logic               RspCarry,
    output logic               Busy
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [2:0]         opsel_q;
    logic               mode_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  result_q;
    logic               rsp_carry_q;
    logic               rsp_valid_q;

    // Sequencer FSM: accept a request, step through the slices, hold the response.
    // NOTE: every register here uses <= so all state updates see the values from
    // before the edge; mixing in blocking assignments would make the slice
    // store and the index increment order-dependent.
    // NOTE: the operand and result registers are reset too, so the slice and
    // response buses read zero out of reset rather than X.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            opsel_q     <= '0;
            mode_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            rsp_carry_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ReqValid) begin
                        opsel_q <= ReqOpsel;
                        mode_q  <= ReqMode;
                        a_q     <= ReqA;
                        b_q     <= ReqB;
                        idx_q   <= '0;
                        carry_q <= initial_carry(ReqOpsel, ReqMode);
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q[idx_q*SLICE_W +: SLICE_W] <= SliceResult;
                    // Logic operations never propagate a carry between slices.
                    carry_q <= mode_q ? 1'b0 : SliceCout;
                    if (idx_q == LAST_IDX) begin
                        rsp_carry_q <= mode_q ? 1'b0 : SliceCout;
                        rsp_valid_q <= 1'b1;
                        idx_q       <= '0;
                        state_q     <= ST_RESP;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_RESP: begin
                    if (RspReady) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Slice drive: current operand slices while executing, zero otherwise.
    // NOTE: defaults are assigned first so no path through this block leaves
    // an output unassigned, which would otherwise infer a latch.
    always_comb begin
        SliceOpsel = '0;
        SliceMode  = 1'b0;
        SliceCin   = 1'b0;
        SliceA     = '0;
        SliceB     = '0;
        if (state_q == ST_EXEC) begin
            SliceOpsel = opsel_q;
            SliceMode  = mode_q;
            SliceCin   = carry_q;
            SliceA     = a_q[idx_q*SLICE_W +: SLICE_W];
            SliceB     = b_q[idx_q*SLICE_W +: SLICE_W];
        end
    end

    assign ReqReady  = (state_q == ST_IDLE);
    assign Busy      = (state_q != ST_IDLE);
    assign RspValid  = rsp_valid_q;
    assign RspResult = result_q;
    assign RspCarry  = rsp_carry_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Testbench for alu_slice_sequencer: behavioural 32-bit slice ALU attached
// to the slice port, full-width reference model, directed plus random ops.
module tb_alu_slice_sequencer;

    localparam int DATA_W  = 128;
    localparam int SLICE_W = 32;
    localparam int NSLICE  = DATA_W / SLICE_W;

    logic               Clk;
    logic               Reset_n;
    logic               ReqValid;
    logic               ReqReady;
    logic [2:0]         ReqOpsel;
    logic               ReqMode;
    logic [DATA_W-1:0]  ReqA;
    logic [DATA_W-1:0]  ReqB;
    logic [2:0]         SliceOpsel;
    logic               SliceMode;
    logic               SliceCin;
    logic [SLICE_W-1:0] SliceA;
    logic [SLICE_W-1:0] SliceB;
    logic [SLICE_W-1:0] SliceResult;
    logic               SliceCout;
    logic               RspValid;
    logic               RspReady;
    logic [DATA_W-1:0]  RspResult;
    logic               RspCarry;
    logic               Busy;

    int n_vec  = 0;
    int n_miss = 0;

    alu_slice_sequencer #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqOpsel   (ReqOpsel),
        .ReqMode    (ReqMode),
        .ReqA       (ReqA),
        .ReqB       (ReqB),
        .SliceOpsel (SliceOpsel),
        .SliceMode  (SliceMode),
        .SliceCin   (SliceCin),
        .SliceA     (SliceA),
        .SliceB     (SliceB),
        .SliceResult(SliceResult),
        .SliceCout  (SliceCout),
        .RspValid   (RspValid),
        .RspReady   (RspReady),
        .RspResult  (RspResult),
        .RspCarry   (RspCarry),
        .Busy       (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural slice ALU, combinational on the slice port.
    always_comb begin
        logic [SLICE_W:0]   sum;
        logic [SLICE_W-1:0] bop;
        sum = '0;
        bop = '0;
        if (SliceMode) begin
            case (SliceOpsel[1:0])
                2'b00:   sum = {1'b0, SliceA & SliceB};
                2'b01:   sum = {1'b0, SliceA | SliceB};
                2'b10:   sum = {1'b0, SliceA ^ SliceB};
                default: sum = {1'b0, ~(SliceA | SliceB)};
            endcase
        end else begin
            case (SliceOpsel[2:1])
                2'b00:   bop = '0;
                2'b01:   bop = SliceB;
                2'b10:   bop = ~SliceB;
                default: bop = '1;
            endcase
            sum = {1'b0, SliceA} + {1'b0, bop} + {{SLICE_W{1'b0}}, SliceCin};
        end
        SliceResult = sum[SLICE_W-1:0];
        SliceCout   = sum[SLICE_W];
    end

    // Carry-in rule for a whole operation.
    function automatic logic ref_cin(input logic [2:0] op, input logic md);
        return !md && (op == 3'b001 || op == 3'b011 || op == 3'b101);
    endfunction

    function automatic logic [DATA_W-1:0] ref_bop(input logic [2:0] op, input logic [DATA_W-1:0] b);
        case (op[2:1])
            2'b00:   return '0;
            2'b01:   return b;
            2'b10:   return ~b;
            default: return '1;
        endcase
    endfunction

    // Full-width reference: {carry, result} of the whole operation.
    function automatic logic [DATA_W:0] ref_op(input logic [2:0] op, input logic md,
                                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (md) begin
            case (op[1:0])
                2'b00:   return {1'b0, a & b};
                2'b01:   return {1'b0, a | b};
                2'b10:   return {1'b0, a ^ b};
                default: return {1'b0, ~(a | b)};
            endcase
        end
        return {1'b0, a} + {1'b0, ref_bop(op, b)} + (DATA_W + 1)'(ref_cin(op, md));
    endfunction

    // Carry entering bit position k*SLICE_W of the full-width addition.
    function automatic logic ref_slice_cin(input logic [2:0] op, input logic md,
                                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                           input int k);
        logic [DATA_W:0] mask;
        logic [DATA_W:0] s;
        if (md) return 1'b0;
        mask = ((DATA_W + 1)'(1) << (k * SLICE_W)) - (DATA_W + 1)'(1);
        s = ({1'b0, a} & mask) + ({1'b0, ref_bop(op, b)} & mask) + (DATA_W + 1)'(ref_cin(op, md));
        return s[k * SLICE_W];
    endfunction

    task automatic check(input string tag, input logic [DATA_W:0] obs, input logic [DATA_W:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_slice_idle(input string tag);
        check(tag, {SliceOpsel, SliceMode, SliceCin, SliceA, SliceB}, '0);
    endtask

    // One operation: issue, check every slice pass, hold the response for
    // `hold` cycles (optionally pulsing ReqValid), then handshake.
    // If abort_at >= 0, reset is asserted while that slice is active.
    task automatic run_op(input logic [2:0] op, input logic md,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input int hold, input bit pulse, input int abort_at);
        logic [DATA_W:0] exp;
        int n;
        n = 0;
        while (!ReqReady && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("req_ready_idle", ReqReady, 1);
        exp = ref_op(op, md, a, b);
        ReqOpsel = op;
        ReqMode  = md;
        ReqA     = a;
        ReqB     = b;
        ReqValid = 1'b1;
        @(negedge Clk);
        ReqValid = 1'b0;
        ReqA     = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < NSLICE; k++) begin
            if (k > 0) @(negedge Clk);
            if (k == abort_at) begin
                Reset_n = 1'b0;
                #1;
                check("rst_rsp_valid", RspValid, 0);
                check("rst_busy", Busy, 0);
                check("rst_result", {RspCarry, RspResult}, '0);
                check_slice_idle("rst_slice");
                @(negedge Clk);
                Reset_n = 1'b1;
                #1;
                check("rst_release_ready", ReqReady, 1);
                check("rst_release_valid", RspValid, 0);
                return;
            end
            check("exec_busy", Busy, 1);
            check("exec_req_ready", ReqReady, 0);
            check("exec_rsp_valid", RspValid, 0);
            check("slice_cin", SliceCin, ref_slice_cin(op, md, a, b, k));
            check("slice_a", SliceA, a[k*SLICE_W +: SLICE_W]);
            check("slice_b", SliceB, b[k*SLICE_W +: SLICE_W]);
            check("slice_ctl", {SliceOpsel, SliceMode}, {op, md});
            RspReady = 1'($urandom);
        end
        @(negedge Clk);
        RspReady = 1'b0;
        check("rsp_valid_latency", RspValid, 1);
        check("rsp_result", RspResult, exp[DATA_W-1:0]);
        check("rsp_carry", RspCarry, exp[DATA_W]);
        check("rsp_req_ready", ReqReady, 0);
        check_slice_idle("rsp_slice_zero");
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 1) begin
                ReqValid = 1'b1;
                ReqOpsel = 3'($urandom);
                ReqMode  = 1'($urandom);
                ReqB     = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge Clk);
            ReqValid = 1'b0;
            check("hold_valid", RspValid, 1);
            check("hold_result", {RspCarry, RspResult}, exp);
            check("hold_req_ready", ReqReady, 0);
            check("hold_busy", Busy, 1);
        end
        RspReady = 1'b1;
        @(negedge Clk);
        RspReady = 1'b0;
        check("done_rsp_valid", RspValid, 0);
        check("done_req_ready", ReqReady, 1);
        check("done_busy", Busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] ra;
        logic [DATA_W-1:0] rb;
        Reset_n  = 1'b0;
        ReqValid = 1'b0;
        ReqOpsel = '0;
        ReqMode  = 1'b0;
        ReqA     = '0;
        ReqB     = '0;
        RspReady = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset_rsp_valid", RspValid, 0);
        check("reset_busy", Busy, 0);
        check("reset_result", {RspCarry, RspResult}, '0);
        check_slice_idle("reset_slice");
        Reset_n = 1'b1;
        @(negedge Clk);
        check("reset_req_ready", ReqReady, 1);

        // Carry ripple through the lower three slices.
        run_op(3'b010, 1'b0, {32'h0, {96{1'b1}}}, 128'd1, 0, 1'b0, -1);
        check("ripple_result", RspResult, 128'h0000_0001_0000_0000_0000_0000_0000_0000);
        // Full overflow.
        run_op(3'b010, 1'b0, '1, 128'd1, 0, 1'b0, -1);
        // Subtract with borrow.
        run_op(3'b101, 1'b0, '0, 128'd1, 0, 1'b0, -1);
        // Logic mode with all-ones carry-producing pattern.
        run_op(3'($urandom), 1'b1, '1, {32{4'h5}}, 1, 1'b0, -1);
        // Backpressure with an ignored request pulse.
        run_op(3'b011, 1'b0, {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, 5, 1'b1, -1);
        // Reset during slice 2, then a fresh small add.
        run_op(3'b010, 1'b0, '1, '1, 0, 1'b0, 2);
        run_op(3'b010, 1'b0, 128'd5, 128'd3, 0, 1'b0, -1);
        check("post_reset_sum", {RspCarry, RspResult}, 129'd8);

        // Random operations, with occasional extreme operands.
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 4) == 0) ra = '1;
            if ($urandom_range(0, 4) == 0) rb = '0;
            run_op(3'($urandom), 1'($urandom), ra, rb,
                   int'($urandom_range(0, 3)), 1'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
- Runs one 128-bit ALU operation as a sequence of narrower passes through a single shared combinational ALU slice, least-significant slice first.
- Computes the initial carry-in from Opsel/Mode using the same rule as CarryGen.
- Chains each slice's carry-out into the next slice and assembles the full-width result.
- Sits between the operand/command source (valid/ready) and the result consumer (valid/ready).

Parameters:
- DATA_W, 128, full operand/result width; must be an integer multiple of SLICE_W.
- SLICE_W, 32, width of the shared ALU slice.
- NSLICE = DATA_W/SLICE_W, local derived constant, not overridable.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept a request.
- ReqOpsel  in  3  operation select.
- ReqMode  in  1  0 = arithmetic, 1 = logic.
- ReqA  in  DATA_W  operand A.
- ReqB  in  DATA_W  operand B.
- SliceOpsel  out  3  opsel driven to the slice.
- SliceMode  out  1  mode driven to the slice.
- SliceCin  out  1  carry-in to the slice.
- SliceA  out  SLICE_W  current A slice.
- SliceB  out  SLICE_W  current B slice.
- SliceResult  in  SLICE_W  slice result, combinational in the same cycle.
- SliceCout  in  1  slice carry-out, combinational in the same cycle.
- RspValid  out  1  result available.
- RspReady  in  1  consumer accepts the result.
- RspResult  out  DATA_W  assembled result.
- RspCarry  out  1  final carry-out; 0 in logic mode.
- Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, Reset_n=0):
  - State = IDLE; slice index, carry register, operand registers and result register all cleared.
  - RspValid=0, RspResult=0, RspCarry=0, Busy=0, all Slice* outputs = 0.
  - ReqReady=1 as soon as reset is released.
- Initial carry (package function):
  - Mode=0: carry=1 for Opsel in {001, 011, 101}; 0 for all other Opsel values.
  - Mode=1: carry=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - ReqReady=1.
  - On an edge with ReqValid=1, latch Opsel, Mode, A, B; index=0; carry register = initial carry; go to EXEC.
- EXEC:
  - ReqReady=0.
  - Drive SliceA/SliceB = A/B bits [index*SLICE_W +: SLICE_W], SliceOpsel/SliceMode = latched values, SliceCin = carry register.
  - Each edge: store SliceResult into result[index]; carry register = SliceCout if Mode=0, else 0; index+1.
  - On the edge where index = NSLICE-1: RspCarry = Mode ? 0 : SliceCout; go to RESP.
- RESP:
  - RspValid=1; RspResult and RspCarry held stable; ReqReady=0.
  - On an edge with RspReady=1, go to IDLE and deassert RspValid.
- Slice outputs are 0 in any state other than EXEC.
- Latency: request accepted at edge T; slice k is active in the cycle after edge T+k; RspValid is high after edge T+NSLICE (4 cycles for the defaults).
- Throughput: one operation outstanding. A new request is accepted no earlier than the edge after the response handshake (ReqReady returns in IDLE), giving a minimum issue interval of NSLICE+2 cycles.
- Boundaries:
  - The index never exceeds NSLICE-1.
  - ReqValid is ignored outside IDLE.
  - RspReady outside RESP has no effect.
  - A reset assertion mid-EXEC or mid-RESP discards the operation; no response is produced.
- The result register is not cleared between operations; RspResult is only meaningful while RspValid=1.

Decomposition:
- Package alu_seq_pkg:
  - State enum {IDLE, EXEC, RESP}.
  - Opsel encoding constants.
  - Function initial_carry(opsel, mode).
- Single module. The slice ALU lives outside the block; the testbench supplies a behavioural 32-bit slice: Mode=0 computes A + (opsel-selected B/~B/0/ones) + Cin, Mode=1 computes bitwise logic.

Test Plan:
- Carry ripple: Opsel=010, Mode=0, A=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=1 -> RspResult=0x0000_0001_0000_0000_0000_0000_0000_0000, RspCarry=0; SliceCin sequence 0,1,1,1.
- Full overflow: Opsel=010, A=all ones, B=1 -> RspResult=0, RspCarry=1; RspValid exactly 4 cycles after the acceptance edge.
- Subtract with borrow: Opsel=101, Mode=0, A=0, B=1 -> RspResult=all ones, RspCarry=0; initial SliceCin=1.
- Logic mode: Mode=1, any Opsel, A=all ones, B=0x5555...5 -> SliceCin=0 on all 4 slices, RspCarry=0, result matches the bitwise model.
- Backpressure: hold RspReady=0 for 5 cycles -> RspValid, RspResult and RspCarry stable; ReqReady=0; a ReqValid pulse is ignored; release -> IDLE the next edge, ReqReady=1.
- Reset mid-operation: assert Reset_n=0 during slice 2 -> all outputs 0 immediately, no RspValid; the next request after reset (A=5, B=3, Opsel=010) -> RspResult=8, RspCarry=0.
